// File: rtl/prog_loader.sv
// Loads a length-prefixed byte stream into instruction memory, then releases the core and times its run.
// Words are written one cycle after their high byte is taken; in_ready is low outside the byte states.
module prog_loader #(
  parameter int PC_W      = 10,
  parameter int DEPTH     = 1024,
  parameter int START_CYC = 2,
  parameter int TIMEOUT   = 65535
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            load_go,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  output logic            imem_wr_en,
  output logic [PC_W-1:0] imem_wr_addr,
  output logic [8:0]      imem_wr_data,
  output logic            start,
  input  logic            done,
  output logic            busy,
  output logic            run_done,
  output logic            err,
  output logic [1:0]      err_code,
  output logic [15:0]     run_cycles
);

  localparam int SC_W = (START_CYC > 1) ? $clog2(START_CYC + 1) : 1;
  localparam logic [SC_W-1:0] ST_LAST = SC_W'(START_CYC - 1);
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI, WRITE, START, RUN, FINISH, ERROR
  } state_t;

  state_t          state, state_nxt;
  logic [15:0]     len;
  logic [PC_W:0]   idx;
  logic [PC_W:0]   idx_inc;
  logic [7:0]      lo_byte;
  logic [8:0]      word;
  logic [SC_W-1:0] st_cnt;
  logic            accept;
  logic [15:0]     len_full;
  logic            len_bad;
  logic            hi_bad;
  logic            last_word;
  logic            timeout_hit;

  assign accept      = in_valid & in_ready;
  assign len_full    = {in_data, len[7:0]};
  assign len_bad     = (len_full == 16'd0) || ({1'b0, len_full} > DEPTH_L);
  assign hi_bad      = (in_data[7:1] != 7'd0);
  assign idx_inc     = idx + 1'b1;
  assign last_word   = (16'(idx_inc) == len);
  assign timeout_hit = (run_cycles == TO_LAST);

  assign imem_wr_addr = idx[PC_W-1:0];
  assign imem_wr_data = word;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    imem_wr_en = 1'b0;
    start      = 1'b1;
    busy       = 1'b1;
    case (state)
      IDLE, FINISH, ERROR: begin
        busy = 1'b0;
        if (load_go) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        in_ready = 1'b1;
        if (accept) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        if (accept) state_nxt = len_bad ? ERROR : DAT_LO;
      end
      DAT_LO: begin
        in_ready = 1'b1;
        if (accept) state_nxt = DAT_HI;
      end
      DAT_HI: begin
        in_ready = 1'b1;
        if (accept) state_nxt = hi_bad ? ERROR : WRITE;
      end
      WRITE: begin
        imem_wr_en = 1'b1;
        state_nxt  = last_word ? START : DAT_LO;
      end
      START: begin
        if (st_cnt == ST_LAST) state_nxt = RUN;
      end
      RUN: begin
        start = 1'b0;
        if (done)             state_nxt = FINISH;
        else if (timeout_hit) state_nxt = ERROR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len        <= '0;
      idx        <= '0;
      lo_byte    <= '0;
      word       <= '0;
      st_cnt     <= '0;
      run_done   <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'd0;
      run_cycles <= '0;
    end else begin
      case (state)
        IDLE, FINISH, ERROR: begin
          if (load_go) begin
            len        <= '0;
            idx        <= '0;
            st_cnt     <= '0;
            run_done   <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'd0;
            run_cycles <= '0;
          end
        end
        LEN_LO: if (accept) len[7:0] <= in_data;
        LEN_HI: begin
          if (accept) begin
            len[15:8] <= in_data;
            if (len_bad) begin
              err      <= 1'b1;
              err_code <= 2'd1;
            end
          end
        end
        DAT_LO: if (accept) lo_byte <= in_data;
        DAT_HI: begin
          // A malformed high byte aborts before the word register changes, so nothing is written.
          if (accept) begin
            if (hi_bad) begin
              err      <= 1'b1;
              err_code <= 2'd2;
            end else begin
              word <= {in_data[0], lo_byte};
            end
          end
        end
        WRITE: begin
          idx    <= idx_inc;
          st_cnt <= '0;
        end
        START: st_cnt <= st_cnt + 1'b1;
        RUN: begin
          // run_cycles freezes on the done cycle; otherwise it counts up to the abort point.
          if (!done) begin
            run_cycles <= run_cycles + 1'b1;
            if (timeout_hit) begin
              err      <= 1'b1;
              err_code <= 2'd3;
            end
          end else begin
            run_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: load, run, bad length, bad high byte, timeout/restart, mid-run reset.
module tb_prog_loader;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_go = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        done = 1'b0;
  logic        in_ready, imem_wr_en, start, busy, run_done, err;
  logic [9:0]  imem_wr_addr;
  logic [8:0]  imem_wr_data;
  logic [1:0]  err_code;
  logic [15:0] run_cycles;

  int passed = 0;
  int fails = 0;
  int total = 0;
  int wr_cnt = 0;
  int base;
  logic [9:0] wa [16];
  logic [8:0] wd [16];

  always #5 clock = ~clock;

  prog_loader #(.PC_W(10), .DEPTH(1024), .START_CYC(2), .TIMEOUT(20)) dut (
    .clock(clock), .reset_n(reset_n), .load_go(load_go), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .imem_wr_en(imem_wr_en),
    .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data), .start(start),
    .done(done), .busy(busy), .run_done(run_done), .err(err),
    .err_code(err_code), .run_cycles(run_cycles)
  );

  always @(posedge clock) begin
    if (imem_wr_en === 1'b1) begin
      wa[wr_cnt & 15] <= imem_wr_addr;
      wd[wr_cnt & 15] <= imem_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic go();
    load_go = 1'b1;
    step();
    load_go = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) step();
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (in_ready !== 1'b1) chk("byte_wait_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    chk("rst_start",      32'(start), 1);
    chk("rst_busy",       32'(busy), 0);
    chk("rst_in_ready",   32'(in_ready), 0);
    chk("rst_wr_en",      32'(imem_wr_en), 0);
    chk("rst_wr_addr",    32'(imem_wr_addr), 0);
    chk("rst_wr_data",    32'(imem_wr_data), 0);
    chk("rst_err",        32'(err), 0);
    chk("rst_err_code",   32'(err_code), 0);
    chk("rst_run_done",   32'(run_done), 0);
    chk("rst_run_cycles", 32'(run_cycles), 0);
    reset_n = 1'b1;
    step();

    // N=3 load with gaps on in_valid
    base = wr_cnt;
    go();
    chk("load_busy",     32'(busy), 1);
    chk("load_in_ready", 32'(in_ready), 1);
    send_byte(8'h03, 0); send_byte(8'h00, 2);
    send_byte(8'hA5, 1); send_byte(8'h01, 0);
    send_byte(8'h00, 3); send_byte(8'h00, 1);
    send_byte(8'hFF, 0); send_byte(8'h00, 2);
    chk("w2_en",   32'(imem_wr_en), 1);
    chk("w2_addr", 32'(imem_wr_addr), 2);
    chk("w2_data", 32'(imem_wr_data), 32'h0FF);
    chk("w2_no_ready", 32'(in_ready), 0);
    step();
    chk("start_c1",  32'(start), 1);
    chk("start_c1_wr", 32'(imem_wr_en), 0);
    step();
    chk("start_c2",  32'(start), 1);
    step();
    chk("start_fall", 32'(start), 0);
    chk("run0_cycles", 32'(run_cycles), 0);
    chk("load_wr_cnt", 32'(wr_cnt - base), 3);
    chk("w0_addr", 32'(wa[base & 15]), 0);
    chk("w0_data", 32'(wd[base & 15]), 32'h1A5);
    chk("w1_addr", 32'(wa[(base + 1) & 15]), 1);
    chk("w1_data", 32'(wd[(base + 1) & 15]), 32'h000);
    chk("w2_addr_log", 32'(wa[(base + 2) & 15]), 2);

    // done in the 10th RUN cycle -> run_cycles 9
    for (int i = 0; i < 9; i++) step();
    chk("run_mid_cycles", 32'(run_cycles), 9);
    chk("run_mid_busy",   32'(busy), 1);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("fin_run_done", 32'(run_done), 1);
    chk("fin_cycles",   32'(run_cycles), 9);
    chk("fin_busy",     32'(busy), 0);
    chk("fin_start",    32'(start), 1);
    chk("fin_err",      32'(err), 0);
    step();
    chk("fin_cycles_frozen", 32'(run_cycles), 9);

    // bad length N=0
    base = wr_cnt;
    go();
    chk("bl0_run_done_clr", 32'(run_done), 0);
    chk("bl0_cycles_clr",   32'(run_cycles), 0);
    send_byte(8'h00, 0); send_byte(8'h00, 1);
    chk("bl0_err",      32'(err), 1);
    chk("bl0_code",     32'(err_code), 1);
    chk("bl0_busy",     32'(busy), 0);
    chk("bl0_in_ready", 32'(in_ready), 0);
    step();
    chk("bl0_no_wr",    32'(wr_cnt - base), 0);

    // bad length N=1025
    go();
    chk("bl1_err_clr",  32'(err), 0);
    chk("bl1_code_clr", 32'(err_code), 0);
    send_byte(8'h01, 0); send_byte(8'h04, 0);
    chk("bl1_err",   32'(err), 1);
    chk("bl1_code",  32'(err_code), 1);
    step();
    chk("bl1_no_wr", 32'(wr_cnt - base), 0);

    // bad high byte on word 1
    base = wr_cnt;
    go();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h34, 0); send_byte(8'h01, 0);
    send_byte(8'h56, 1); send_byte(8'h03, 0);
    chk("bh_err",   32'(err), 1);
    chk("bh_code",  32'(err_code), 2);
    chk("bh_start", 32'(start), 1);
    chk("bh_wr_en", 32'(imem_wr_en), 0);
    step(); step();
    chk("bh_wr_cnt", 32'(wr_cnt - base), 1);
    chk("bh_addr",   32'(wa[base & 15]), 0);
    chk("bh_data",   32'(wd[base & 15]), 32'h134);

    // timeout, with a stale done held during START
    base = wr_cnt;
    go();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h77, 0); send_byte(8'h00, 0);
    chk("to_wr_en", 32'(imem_wr_en), 1);
    done = 1'b1;
    step();
    chk("to_stale_start1", 32'(start), 1);
    step();
    chk("to_stale_start2", 32'(start), 1);
    done = 1'b0;
    step();
    chk("to_run_start",    32'(start), 0);
    chk("to_run_done_no",  32'(run_done), 0);
    for (int i = 0; i < 19; i++) step();
    chk("to_c19",    32'(run_cycles), 19);
    chk("to_c19_err", 32'(err), 0);
    step();
    chk("to_err",    32'(err), 1);
    chk("to_code",   32'(err_code), 3);
    chk("to_start",  32'(start), 1);
    chk("to_busy",   32'(busy), 0);
    chk("to_cycles", 32'(run_cycles), 20);
    chk("to_wr_data", 32'(wd[base & 15]), 32'h077);

    // restart after timeout, then reset mid-run
    go();
    chk("rs_err_clr",    32'(err), 0);
    chk("rs_code_clr",   32'(err_code), 0);
    chk("rs_cycles_clr", 32'(run_cycles), 0);
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hFF, 0); send_byte(8'h01, 0);
    chk("rs_wr_addr", 32'(imem_wr_addr), 0);
    chk("rs_wr_data", 32'(imem_wr_data), 32'h1FF);
    step(); step(); step();
    chk("rs_run", 32'(start), 0);
    step(); step(); step();
    chk("rs_cycles3", 32'(run_cycles), 3);
    reset_n = 1'b0;
    #1;
    chk("ar_start",  32'(start), 1);
    chk("ar_busy",   32'(busy), 0);
    chk("ar_err",    32'(err), 0);
    chk("ar_wr_en",  32'(imem_wr_en), 0);
    chk("ar_cycles", 32'(run_cycles), 0);
    #2;
    reset_n = 1'b1;
    step();
    chk("ar_idle_busy",  32'(busy), 0);
    chk("ar_idle_ready", 32'(in_ready), 0);
    chk("ar_idle_start", 32'(start), 1);

    // session after reset, done on the first RUN cycle
    go();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hAB, 0); send_byte(8'h00, 0);
    chk("pr_wr_data", 32'(imem_wr_data), 32'h0AB);
    step(); step(); step();
    chk("pr_run", 32'(start), 0);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("pr_run_done", 32'(run_done), 1);
    chk("pr_cycles",   32'(run_cycles), 0);
    chk("pr_busy",     32'(busy), 0);
    chk("pr_start",    32'(start), 1);
    chk("total_writes", 32'(wr_cnt), 7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
